// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous signal in clk_in cycles and
// hands each result to a consumer through a valid/ready register with sticky flags.
module period_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TIMEOUT     = 32'd200000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             sig_in,
    input  logic             enable_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             timeout_out,
    output logic             overrun_out
);

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s_c;
    logic                   rise_c;
    logic [WIDTH-1:0]       cnt_q, cnt_nxt;
    logic [WIDTH-1:0]       hcnt_q, hcnt_nxt;
    logic                   publish_c;
    logic                   timeout_set_c;
    logic [WIDTH-1:0]       period_nxt, high_nxt;
    logic                   valid_nxt, timeout_nxt, overrun_nxt;

    // Synchronized level and its rising edge; fixed latency cancels out of every interval.
    assign s_c    = sync_q[SYNC_STAGES-1];
    assign rise_c = s_c & ~s_d_q;

    // Next-state, counter and result-register logic.
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        hcnt_nxt      = hcnt_q;
        publish_c     = 1'b0;
        timeout_set_c = 1'b0;
        period_nxt    = period_out;
        high_nxt      = high_out;
        valid_nxt     = valid_out;
        timeout_nxt   = timeout_out;
        overrun_nxt   = overrun_out;

        case (state_q)
            IDLE: begin
                cnt_nxt  = '0;
                hcnt_nxt = '0;
                if (enable_in && rise_c) begin
                    cnt_nxt   = ONE_W;
                    hcnt_nxt  = ONE_W;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable_in) begin
                    cnt_nxt   = '0;
                    hcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else if (rise_c) begin
                    // The closing edge also opens the next period, so it counts as high.
                    publish_c = 1'b1;
                    cnt_nxt   = ONE_W;
                    hcnt_nxt  = ONE_W;
                end else if (cnt_q == TIMEOUT_W) begin
                    timeout_set_c = 1'b1;
                    cnt_nxt       = '0;
                    hcnt_nxt      = '0;
                    state_nxt     = IDLE;
                end else begin
                    cnt_nxt  = cnt_q + ONE_W;
                    hcnt_nxt = hcnt_q + WIDTH'(s_c);
                end
            end
            default: begin
                cnt_nxt   = '0;
                hcnt_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase

        if (publish_c) begin
            period_nxt  = cnt_q;
            high_nxt    = hcnt_q;
            valid_nxt   = 1'b1;
            timeout_nxt = 1'b0;
            if (valid_out && !ready_in) begin
                overrun_nxt = 1'b1;
            end
        end else begin
            if (valid_out && ready_in) begin
                valid_nxt = 1'b0;
            end
            if (timeout_set_c) begin
                timeout_nxt = 1'b1;
            end
        end
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync_q      <= '0;
            s_d_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_out  <= '0;
            high_out    <= '0;
            valid_out   <= 1'b0;
            timeout_out <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d_q       <= s_c;
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            hcnt_q      <= hcnt_nxt;
            period_out  <= period_nxt;
            high_out    <= high_nxt;
            valid_out   <= valid_nxt;
            timeout_out <= timeout_nxt;
            overrun_out <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: timestamp-based reference model compared every cycle,
// plus hand-computed literal expectations after each directed scenario.
module tb_period_meter;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 120;
    localparam int unsigned SS = 2;

    logic         clk_in    = 1'b0;
    logic         rst_n_in  = 1'b0;
    logic         sig_in    = 1'b0;
    logic         enable_in = 1'b0;
    logic         ready_in  = 1'b0;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         valid_out;
    logic         timeout_out;
    logic         overrun_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    period_meter #(
        .WIDTH       (W),
        .TIMEOUT     (TO),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .sig_in      (sig_in),
        .enable_in   (enable_in),
        .period_out  (period_out),
        .high_out    (high_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .timeout_out (timeout_out),
        .overrun_out (overrun_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: sig_in samples by clock edge number; the measured signal is that
    // history seen SS edges later, and results follow from rise timestamps.
    bit  hist [0:32767];
    int  cyc      = 0;
    int  rst_cyc  = -1;
    bit  started  = 1'b0;
    bit  armed    = 1'b0;
    int  last_rise = 0;
    bit  m_valid = 1'b0, m_to = 1'b0, m_ov = 1'b0;
    int  m_per = 0, m_hi = 0;

    function automatic bit lk(input int idx);
        if (idx <= rst_cyc || idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    always @(posedge clk_in) begin : model
        bit sv, sp, rise, pub, tos;
        int p, h;
        cyc++;
        if (!rst_n_in) begin
            rst_cyc = cyc;
            started = 1'b1;
            armed   = 1'b0;
            m_valid = 1'b0;
            m_to    = 1'b0;
            m_ov    = 1'b0;
            m_per   = 0;
            m_hi    = 0;
        end else begin
            sv   = lk(cyc - SS);
            sp   = lk(cyc - SS - 1);
            rise = sv && !sp;
            pub  = 1'b0;
            tos  = 1'b0;
            p    = 0;
            h    = 0;
            if (!enable_in) begin
                armed = 1'b0;
            end else if (!armed) begin
                if (rise) begin
                    armed     = 1'b1;
                    last_rise = cyc;
                end
            end else if (rise) begin
                pub = 1'b1;
                p   = cyc - last_rise;
                for (int j = last_rise; j < cyc; j++) h += int'(lk(j - SS));
                last_rise = cyc;
            end else if (cyc - last_rise == int'(TO)) begin
                armed = 1'b0;
                tos   = 1'b1;
            end
            if (pub) begin
                if (m_valid && !ready_in) m_ov = 1'b1;
                m_valid = 1'b1;
                m_per   = p;
                m_hi    = h;
                m_to    = 1'b0;
            end else begin
                if (m_valid && ready_in) m_valid = 1'b0;
                if (tos) m_to = 1'b1;
            end
            hist[cyc] = sig_in;
        end
    end

    always @(negedge clk_in) begin
        if (started) begin
            chk("cyc_valid",   32'(valid_out),   32'(m_valid));
            chk("cyc_period",  32'(period_out),  32'(m_per));
            chk("cyc_high",    32'(high_out),    32'(m_hi));
            chk("cyc_timeout", 32'(timeout_out), 32'(m_to));
            chk("cyc_overrun", 32'(overrun_out), 32'(m_ov));
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            sig_in = 1'b1;
            cyc_n(h);
            sig_in = 1'b0;
            cyc_n(p - h);
        end
    endtask

    task automatic chk_result(input string tag, input int p, input int h);
        chk({tag, "_period"}, 32'(period_out), 32'(p));
        chk({tag, "_high"},   32'(high_out),   32'(h));
    endtask

    initial begin
        cyc_n(2);
        chk("rst_valid",   32'(valid_out),   32'd0);
        chk("rst_period",  32'(period_out),  32'd0);
        chk("rst_overrun", 32'(overrun_out), 32'd0);
        rst_n_in  = 1'b1;
        enable_in = 1'b1;
        ready_in  = 1'b1;
        cyc_n(4);

        // 1: period 10 / high 4, consumer always ready
        sig_in = 1'b1;
        cyc_n(4);
        sig_in = 1'b0;
        cyc_n(6);
        chk("t1_arm_only", 32'(valid_out), 32'd0);
        wave(10, 4, 5);
        chk_result("t1", 10, 4);
        chk("t1_valid",   32'(valid_out),   32'd0);
        chk("t1_timeout", 32'(timeout_out), 32'd0);
        chk("t1_overrun", 32'(overrun_out), 32'd0);

        // 2: consumer stalls for 3 results
        ready_in = 1'b0;
        wave(10, 4, 3);
        chk("t2_valid",   32'(valid_out),   32'd1);
        chk("t2_overrun", 32'(overrun_out), 32'd1);
        chk_result("t2", 10, 4);
        ready_in = 1'b1;
        cyc_n(1);
        chk("t2_drop",    32'(valid_out),   32'd0);
        chk("t2_sticky",  32'(overrun_out), 32'd1);

        // 3: force IDLE, arm with a single rise, hold high until timeout
        enable_in = 1'b0;
        cyc_n(3);
        enable_in = 1'b1;
        cyc_n(2);
        sig_in = 1'b1;
        cyc_n(TO + 2);
        chk("t3_before_to", 32'(timeout_out), 32'd0);
        cyc_n(1);
        chk("t3_at_to",     32'(timeout_out), 32'd1);
        chk("t3_no_valid",  32'(valid_out),   32'd0);
        sig_in = 1'b0;
        cyc_n(5);
        wave(20, 8, 3);
        chk_result("t3", 20, 8);
        chk("t3_to_clear", 32'(timeout_out), 32'd0);

        // 4: enable dropped mid-period while a result is pending
        ready_in = 1'b0;
        wave(30, 12, 2);
        chk_result("t4_pend", 30, 12);
        sig_in = 1'b1;
        cyc_n(12);
        sig_in = 1'b0;
        cyc_n(5);
        enable_in = 1'b0;
        cyc_n(5);
        enable_in = 1'b1;
        cyc_n(8);
        chk("t4_hold_valid", 32'(valid_out), 32'd1);
        chk_result("t4_hold", 30, 12);
        ready_in = 1'b1;
        wave(30, 12, 3);
        chk_result("t4", 30, 12);

        // 5: minimum signal and duty sweep
        wave(2, 1, 6);
        chk_result("t5_min", 2, 1);
        wave(100, 1, 3);
        chk_result("t5_d1", 100, 1);
        wave(100, 50, 3);
        chk_result("t5_d50", 100, 50);
        wave(100, 99, 3);
        chk_result("t5_d99", 100, 99);

        // 6: reset with valid, overrun and a measurement in progress
        ready_in = 1'b0;
        wave(10, 4, 3);
        chk("t6_pre_valid",   32'(valid_out),   32'd1);
        chk("t6_pre_overrun", 32'(overrun_out), 32'd1);
        sig_in = 1'b1;
        cyc_n(4);
        sig_in = 1'b0;
        cyc_n(2);
        rst_n_in = 1'b0;
        cyc_n(1);
        rst_n_in = 1'b1;
        chk("t6_valid",   32'(valid_out),   32'd0);
        chk("t6_overrun", 32'(overrun_out), 32'd0);
        chk_result("t6_rst", 0, 0);
        cyc_n(4);
        wave(10, 4, 1);
        chk("t6_arm_only", 32'(valid_out), 32'd0);
        sig_in = 1'b1;
        cyc_n(3);
        chk("t6_publish", 32'(valid_out), 32'd1);
        chk_result("t6", 10, 4);
        sig_in = 1'b0;
        cyc_n(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures an external periodic signal against the system clock: the period and the high time, both in clk_in cycles.
- It is the measuring counterpart to the team's clock dividers. It self-checks divider outputs and measures external tick or sensor signals.
- Results go to the consumer through a valid/ready register, with sticky timeout and overrun flags.

Parameters:
- WIDTH, 32, width of the period and high-time counters and result outputs.
- TIMEOUT, 32'd200000000, cycles without a rising edge before abandoning a measurement. Must be < 2^WIDTH and >= 2.
- SYNC_STAGES, 2, synchronizer flops on sig_in. Must be >= 2.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  synchronous, active-low reset.
- sig_in  input  1  signal under measurement, asynchronous to clk_in.
- enable_in  input  1  measurement enable.
- period_out  output  WIDTH  last measured period, rising edge to rising edge, in cycles.
- high_out  output  WIDTH  high cycles within that period.
- valid_out  output  1  result held and unconsumed.
- ready_in  input  1  consumer accepts the result when valid_out and ready_in are both 1.
- timeout_out  output  1  sticky; last measurement attempt timed out.
- overrun_out  output  1  sticky; a result was overwritten before it was consumed.

Behaviour:
- Reset (rst_n_in=0 at a clk_in edge):
  - All outputs become 0.
  - Synchronizer, edge-detect flop and counters are cleared; state goes to IDLE.
  - Reset overrides everything, including a measurement in progress or a pending valid.
- Input path:
  - sig_in passes through SYNC_STAGES flops, giving s.
  - One more flop gives s_d; rise = s & ~s_d.
  - Latency is fixed, so it does not bias the measurements.
- State IDLE:
  - Counters are held at 0.
  - If enable_in=1 and rise: cnt<=1, hcnt<=1, go to MEASURE.
  - Nothing is published. The first edge only arms.
- State MEASURE, when rise=0:
  - cnt<=cnt+1.
  - hcnt<=hcnt+1 if s=1.
- State MEASURE, when rise=1:
  - Publish period_out<=cnt and high_out<=hcnt; timeout_out<=0.
  - cnt<=1, hcnt<=1; stay in MEASURE.
  - Result: a synchronized signal with period P and high time H publishes P and H.
- Timeout (MEASURE, cnt==TIMEOUT, rise=0):
  - timeout_out<=1, go to IDLE, no publish.
  - If rise occurs in the same cycle as cnt==TIMEOUT, the rise wins: TIMEOUT is published normally.
- enable_in=0:
  - Next state is IDLE and counters clear; any in-progress measurement is discarded.
  - Result registers, valid_out and the sticky flags hold their values.
- Output handshake:
  - A publish sets valid_out<=1 and loads the data.
  - valid_out clears at the edge where valid_out & ready_in holds and no publish occurs.
  - Publish while valid_out=1 and ready_in=0: data is overwritten, valid_out stays 1, overrun_out<=1.
  - Publish while valid_out=1 and ready_in=1: the old result counts as consumed, the new one loads, valid_out stays 1, no overrun.
  - period_out and high_out are stable while valid_out=1 except on a publish.
- Sticky flags:
  - overrun_out clears only on reset.
  - timeout_out clears on reset or on the next publish.
- Arithmetic: counters are unsigned WIDTH bits. cnt never exceeds TIMEOUT, so there is no wrap.
- Minimum measurable signal: period 2 cycles, high 1 cycle after synchronization.
  - sig_in constant high or constant low produces a timeout after arming.
  - With no edge ever, the block stays in IDLE silently.

Test Plan:
1. enable_in=1, ready_in=1, sig_in square wave with period 10 cycles and high 4 -> no valid after the first rise. Then valid_out pulses for 1 cycle every 10 cycles with period_out=10, high_out=4; flags stay 0.
2. Same wave, ready_in=0 for 3 periods, then ready_in=1 -> overrun_out=1 after the second result. Data is 10/4 from the latest result; valid_out drops the cycle after ready_in rises; overrun_out stays 1.
3. TIMEOUT=50: one rise, then sig_in held low -> timeout_out=1 exactly 50 cycles after arming, no valid. Then a period-20 wave -> the first valid shows period_out=20 and timeout_out returns to 0 on that publish.
4. Period-30 wave; drop enable_in for 5 cycles mid-period, then restore -> no result for the interrupted period, and the first rise after re-enable only arms. The next result is 30; a previously pending valid/data is preserved throughout.
5. Minimum signal (period 2, high 1) and a duty sweep (period 100, high 1/50/99) -> published values exact every period.
6. Assert rst_n_in for 1 cycle while valid_out=1, overrun_out=1 and a measurement is in progress -> all outputs 0 at the next edge. After release, the first rise arms and the second rise publishes.
